// File: rtl/phy_reg_status.sv
// phy_reg_status: speculative/committed rename state with commit release and flush recovery
module phy_reg_status #(
  parameter int RB = 2,
  parameter int RP = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [32*RB-1:0]  rnAct_X_dnxt,
  output logic [32*RB-1:0]  rnAct_X_qout,
  input  logic [32*RP-1:0]  rnBufU_rename_set,
  output logic [32*RP-1:0]  rnBufU_qout,
  output logic [32*RP-1:0]  wbLog_qout,
  output logic [32*RB-1:0]  archi_X_qout,
  input  logic              wb_vaild,
  input  logic [4+RB:0]     wb_rd,
  input  logic              commit_vaild,
  input  logic [4+RB:0]     commit_rd,
  input  logic              flush,
  output logic              rn_block
);
  typedef enum logic {NORMAL, RECOVER} state_e;
  localparam logic [32*RP-1:0] ONE = {{(32*RP-1){1'b0}}, 1'b1};
  localparam logic [32*RP-1:0] RST_BITS = {32{{(RP-1){1'b0}}, 1'b1}};
  localparam logic [32*RP-1:0] NO_X0_RP = {{(31*RP){1'b1}}, {RP{1'b0}}};
  localparam logic [32*RB-1:0] NO_X0_RB = {{(31*RB){1'b1}}, {RB{1'b0}}};
  state_e state_q, state_d;
  logic [32*RB-1:0] rn_act_q, rn_act_d, archi_q, archi_d;
  logic [32*RP-1:0] rn_bufu_q, rn_bufu_d, wb_log_q, wb_log_d;
  logic [32*RP-1:0] rel_mask, ren_set, wb_mask, commit_oh;
  logic [4:0] c_r, w_r;
  logic [RB-1:0] c_c, old_c;
  logic commit_en;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) state_q <= NORMAL;
    else state_q <= state_d;
  always_comb state_d = flush ? RECOVER : NORMAL;
  always_comb rn_block = flush | (state_q == RECOVER);
  always_comb begin
    c_r = commit_rd[RB+:5];
    c_c = commit_rd[RB-1:0];
    w_r = wb_rd[RB+:5];
    old_c = archi_q[c_r*RB+:RB];
    commit_en = commit_vaild && c_r != 5'd0;
    archi_d = archi_q;
    if (commit_en) archi_d[c_r*RB+:RB] = c_c;
    rel_mask = (commit_en && c_c != old_c) ? ONE << {c_r, old_c} : '0;
    ren_set = rn_block ? '0 : rnBufU_rename_set & NO_X0_RP;
    wb_mask = (wb_vaild && w_r != 5'd0) ? ONE << wb_rd : '0;
    commit_oh = '0;
    for (int r = 0; r < 32; r++) commit_oh[r*RP+:RP] = RP'(1) << archi_d[r*RB+:RB];
    rn_act_d = flush ? archi_d : rn_block ? rn_act_q : rnAct_X_dnxt & NO_X0_RB;
    rn_bufu_d = flush ? commit_oh : (rn_bufu_q | ren_set) & ~rel_mask;
    wb_log_d = flush ? commit_oh : (wb_log_q & ~ren_set & ~rel_mask) | wb_mask;
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      rn_act_q <= '0;
      archi_q <= '0;
      rn_bufu_q <= RST_BITS;
      wb_log_q <= RST_BITS;
    end else begin
      rn_act_q <= rn_act_d;
      archi_q <= archi_d;
      rn_bufu_q <= rn_bufu_d;
      wb_log_q <= wb_log_d;
    end
  assign rnAct_X_qout = rn_act_q;
  assign archi_X_qout = archi_q;
  assign rnBufU_qout = rn_bufu_q;
  assign wbLog_qout = wb_log_q;
endmodule

// File: tb/tb_phy_reg_status.sv
// tb_phy_reg_status: directed scoreboard bench for phy_reg_status
module tb_phy_reg_status;
  logic CLK = 1'b0;
  logic RSTn;
  logic [63:0] rnAct_X_dnxt, rnAct_X_qout, archi_X_qout;
  logic [127:0] rnBufU_rename_set, rnBufU_qout, wbLog_qout;
  logic wb_vaild, commit_vaild, flush, rn_block;
  logic [6:0] wb_rd, commit_rd;
  phy_reg_status #(.RB(2), .RP(4)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .rnAct_X_dnxt(rnAct_X_dnxt), .rnAct_X_qout(rnAct_X_qout),
    .rnBufU_rename_set(rnBufU_rename_set), .rnBufU_qout(rnBufU_qout),
    .wbLog_qout(wbLog_qout), .archi_X_qout(archi_X_qout),
    .wb_vaild(wb_vaild), .wb_rd(wb_rd),
    .commit_vaild(commit_vaild), .commit_rd(commit_rd),
    .flush(flush), .rn_block(rn_block)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [63:0] act;
    logic [63:0] arch;
    logic [127:0] bufu;
    logic [127:0] wb;
    logic blk;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [63:0] e_act, e_arch;
  logic [127:0] e_bufu, e_wb;
  localparam logic [127:0] RST_BITS = {32{4'b0001}};
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, b);
    end
  endtask
  function automatic logic [63:0] with_field(input logic [63:0] v, input int r, input logic [1:0] c);
    logic [63:0] t;
    t = v;
    t[r*2+:2] = c;
    return t;
  endfunction
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("rnAct", {64'd0, rnAct_X_qout}, {64'd0, e.act});
      chk("archi", {64'd0, archi_X_qout}, {64'd0, e.arch});
      chk("rnBufU", rnBufU_qout, e.bufu);
      chk("wbLog", wbLog_qout, e.wb);
      chk("rn_block", {127'd0, rn_block}, {127'd0, e.blk});
    end
    if (RSTn && !flush) begin
      if (wb_vaild && wb_rd[6:2] != 0 && !rn_block && rnBufU_rename_set[wb_rd]) begin
        errors++;
        $display("FAIL proto_rename_wb_same_bit got bit %0d want disjoint", wb_rd);
      end
      if (wb_vaild && wb_rd[6:2] != 0 && !rnBufU_qout[wb_rd]) begin
        errors++;
        $display("FAIL proto_wb_unallocated got bit %0d want allocated", wb_rd);
      end
    end
    if (RSTn && commit_vaild && commit_rd[6:2] != 0) begin
      if (commit_rd[1:0] == archi_X_qout[commit_rd[6:2]*2+:2]) begin
        errors++;
        $display("FAIL proto_commit_same_copy got %0d want differing copy", commit_rd);
      end else if (!rn_block && rnBufU_rename_set[{commit_rd[6:2], archi_X_qout[commit_rd[6:2]*2+:2]}]) begin
        errors++;
        $display("FAIL proto_rename_release_same_bit got %0d want disjoint", commit_rd);
      end
    end
  end
  task automatic cyc(input logic [127:0] set, input logic [63:0] dnxt, input logic wv, input logic [6:0] wr,
                     input logic cv, input logic [6:0] cr, input logic fl, input logic blk);
    @(posedge CLK);
    #2;
    rnBufU_rename_set = set;
    rnAct_X_dnxt = dnxt;
    wb_vaild = wv;
    wb_rd = wr;
    commit_vaild = cv;
    commit_rd = cr;
    flush = fl;
    q.push_back('{e_act, e_arch, e_bufu, e_wb, blk});
  endtask
  task automatic idle(input logic blk);
    cyc('0, e_act, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, blk);
  endtask
  task automatic ren(input int r, input int c);
    cyc(128'd1 << (r*4+c), with_field(e_act, r, 2'(c)), 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0);
  endtask
  task automatic reset_exp();
    e_act = '0;
    e_arch = '0;
    e_bufu = RST_BITS;
    e_wb = RST_BITS;
  endtask
  initial begin
    RSTn = 1'b0;
    rnBufU_rename_set = '0;
    rnAct_X_dnxt = '0;
    wb_vaild = 1'b0;
    wb_rd = '0;
    commit_vaild = 1'b0;
    commit_rd = '0;
    flush = 1'b0;
    reset_exp();
    idle(1'b0);
    RSTn = 1'b1;
    idle(1'b0);
    ren(5, 1);
    e_bufu[21] = 1'b1;
    e_act[11:10] = 2'd1;
    cyc('0, e_act, 1'b1, 7'd21, 1'b0, 7'd0, 1'b0, 1'b0);
    e_wb[21] = 1'b1;
    cyc('0, e_act, 1'b0, 7'd0, 1'b1, 7'd21, 1'b0, 1'b0);
    e_arch[11:10] = 2'd1;
    e_bufu[20] = 1'b0;
    e_wb[20] = 1'b0;
    ren(7, 1);
    e_bufu[29] = 1'b1;
    e_act[15:14] = 2'd1;
    ren(7, 2);
    e_bufu[30] = 1'b1;
    e_act[15:14] = 2'd2;
    ren(7, 3);
    e_bufu[31] = 1'b1;
    e_act[15:14] = 2'd3;
    cyc(128'd1 << 37, with_field(e_act, 9, 2'd1), 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);
    e_act[15:14] = 2'd0;
    e_bufu[31:28] = 4'b0001;
    cyc(128'd1 << 37, with_field(e_act, 9, 2'd1), 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    idle(1'b0);
    ren(7, 2);
    e_bufu[30] = 1'b1;
    e_act[15:14] = 2'd2;
    cyc('0, e_act, 1'b0, 7'd0, 1'b1, 7'd30, 1'b1, 1'b1);
    e_arch[15:14] = 2'd2;
    e_bufu[31:28] = 4'b0100;
    e_wb[31:28] = 4'b0100;
    idle(1'b1);
    idle(1'b0);
    cyc(128'd2, with_field(e_act, 0, 2'd1), 1'b1, 7'd2, 1'b1, 7'd2, 1'b0, 1'b0);
    idle(1'b0);
    cyc('0, e_act, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);
    @(posedge CLK);
    #2;
    RSTn = 1'b0;
    rnBufU_rename_set = '0;
    rnAct_X_dnxt = '0;
    flush = 1'b0;
    reset_exp();
    q.push_back('{e_act, e_arch, e_bufu, e_wb, 1'b0});
    idle(1'b0);
    RSTn = 1'b1;
    idle(1'b0);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge CLK);
    @(posedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phy_reg_status.md
Name: phy_reg_status

Overview:
- Holds the speculative and committed state of the renamed integer register file: rename map, committed map, per-copy allocation bits, per-copy written bits.
- Sits beside the rename stage. It registers the rename stage's next-state outputs and feeds them back as current state.
- Releases superseded physical copies on commit.
- Restores rename state from the committed map on pipeline flush, with a one-cycle recovery block.

Parameters:
- RB, 2, bits of physical-copy index per architectural register.
- RP, 4, physical copies per architectural register; must equal 2**RB.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- rnAct_X_dnxt  input  32*RB  next speculative map from rename stage; field i = copy index for xi.
- rnAct_X_qout  output  32*RB  current speculative map.
- rnBufU_rename_set  input  32*RP  one-hot allocation request from rename stage (bit RP*r+c); zero or one bit set.
- rnBufU_qout  output  32*RP  allocation (in-use) bits.
- wbLog_qout  output  32*RP  written bits; 1 = copy holds valid result.
- archi_X_qout  output  32*RB  committed map.
- wb_vaild  input  1  writeback strobe.
- wb_rd  input  5+RB  writeback destination {r, c}.
- commit_vaild  input  1  commit strobe for an instruction with destination.
- commit_rd  input  5+RB  committed destination {r, c}.
- flush  input  1  pipeline flush; single-cycle pulse.
- rn_block  output  1  rename stage must not allocate or update the map this cycle.

Behaviour:
- Reset (RSTn low, asynchronous): rnAct_X_qout=0, archi_X_qout=0.
- Reset: rnBufU_qout and wbLog_qout have only bit RP*r set for every r, so copy 0 of each register is architectural and written.
- Reset: FSM=NORMAL, rn_block=0.
- Register x0: fields for r=0 are never modified. Rename, writeback and commit targeting r=0 are ignored. Copy 0 of x0 stays allocated and written.
- FSM states: NORMAL and RECOVER.
  - NORMAL -> RECOVER when flush=1.
  - RECOVER -> NORMAL unconditionally after one cycle.
  - A flush arriving in RECOVER re-enters RECOVER.
- rn_block = flush | (state==RECOVER). This is combinational, 0-latency.
- Normal cycle (flush=0):
  - rnAct_X <= rnAct_X_dnxt, but only when rn_block=0; otherwise it holds.
  - rnBufU <= (rnBufU | rename_set) & ~release_mask. rename_set is ignored while rn_block=1.
  - wbLog <= (wbLog & ~rename_set & ~release_mask) | wb_mask.
  - wb_mask = wb_vaild ? 1<<wb_rd : 0.
- Commit, with commit_rd={r,c} and r!=0:
  - archi_X[r] <= c.
  - release_mask = 1<<{r, archi_X_qout[r]}, using the old committed copy.
  - If c equals the old committed copy, release_mask=0. This is a protocol error and the bench asserts on it.
- Flush cycle (flush=1), highest priority:
  - Commit in the same cycle is applied first, giving archi_next.
  - rnAct_X <= archi_next.
  - rnBufU <= one-hot of archi_next per register.
  - wbLog <= rnBufU next value (committed copies are by definition written).
  - rename_set, rnAct_X_dnxt and wb_vaild are ignored.
- Simultaneous events:
  - Rename and writeback of the same bit: writeback wins. This is illegal; assert.
  - Rename and release of the same bit: release wins. This is illegal because an allocated bit is never free; assert.
- Writeback to an unallocated copy: wbLog bit is still set. The bench flags it as an error.
- Latency: every update is visible on the qout outputs one cycle after the input cycle. No combinational path from inputs to qout outputs.
- Reset asserted mid-flush or mid-RECOVER: returns immediately to reset values and NORMAL.

Test Plan:
- Reset release -> rnBufU_qout and wbLog_qout have bits 0,4,8,...,124 set (RP=4). All maps 0. rn_block=0.
- Rename x5 to copy 1 (rename_set bit 21, dnxt field5=1) -> next cycle rnBufU bit 21=1, wbLog bit 21=0, rnAct field5=1. Then wb_rd={5,1} -> wbLog bit 21=1.
- Commit {5,1} after the above -> archi field5=1. Bits 20 cleared in rnBufU and wbLog. Bit 21 remains.
- Rename x7 to copies 1, 2 and 3 in successive cycles with no commit -> nibble 7 of rnBufU=4'b1111. Then flush -> rnAct field7=0, nibble 7=4'b0001. rn_block=1 in the flush cycle and the next cycle, then 0.
- Same-cycle commit {7,2} and flush -> archi field7=2, rnAct field7=2, nibble 7=4'b0100, wbLog nibble 7=4'b0100.
- Rename, writeback and commit to x0 -> no state change. Assert RSTn low while in RECOVER -> all outputs return to reset values asynchronously.
